// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
//   tx_state_t       : serialiser FSM states
//   ST_*             : bit positions inside the status word
//   DEF_*_ADDR       : default register byte addresses
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_FULL  = 2;
  localparam int unsigned ST_OVF   = 3;

  localparam logic [31:0] DEF_TX_ADDR     = 32'h0000_4000;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_4004;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-store bus as seen by the UART transmitter.
//   mem_write  : store strobe, one cycle per store
//   data_addr  : store/load byte address
//   write_data : store data
//   rd_data    : combinational read data returned by the peripheral
// master = core side, slave = peripheral side.
interface mmio_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output mem_write, data_addr, write_data, input rd_data);
  modport slave  (input mem_write, data_addr, write_data, output rd_data);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pointer-compare full/empty flags.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write strobe and data (caller must not push when full
//                unless popping in the same cycle)
//   pop, dout  : read strobe and head-of-queue data (dout is valid while
//                !empty; caller must not pop when empty)
//   full,empty : occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's store bus.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : store bus (slave); stores to TX_ADDR queue a byte, stores
//                to STATUS_ADDR with bit3 set clear overflow, reads of
//                STATUS_ADDR return {overflow, full, empty, busy}
//   uart_tx    : serial line, idle high
//   tx_busy    : serialiser not idle
//   overflow   : sticky, a byte was dropped on a full FIFO
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TX_ADDR      = DATA_WIDTH'(DEF_TX_ADDR),
  parameter logic [DATA_WIDTH-1:0] STATUS_ADDR  = DATA_WIDTH'(DEF_STATUS_ADDR),
  parameter int unsigned           FIFO_DEPTH   = 8,
  parameter int unsigned           CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                reset,
  mmio_uart_tx_if.slave       bus,
  output logic                uart_tx,
  output logic                tx_busy,
  output logic                overflow
);

  localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic       push_req;
  logic       push;
  logic       pop;
  logic       ovf_clr;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  assign push_req = bus.mem_write && (bus.data_addr == TX_ADDR);
  assign ovf_clr  = bus.mem_write && (bus.data_addr == STATUS_ADDR) && bus.write_data[ST_OVF];
  assign pop      = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a byte when the FSM frees a slot this cycle.
  assign push     = push_req && (!fifo_full || pop);
  assign tx_busy  = (state != IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.write_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    bus.rd_data = '0;
    if (bus.data_addr == STATUS_ADDR) begin
      bus.rd_data[ST_BUSY]  = tx_busy;
      bus.rd_data[ST_EMPTY] = fifo_empty;
      bus.rd_data[ST_FULL]  = fifo_full;
      bus.rd_data[ST_OVF]   = overflow;
    end
  end

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_req && !push) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            shift   <= fifo_dout;
            uart_tx <= 1'b0;
            cnt     <= '0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            bit_idx <= '0;
            uart_tx <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] TX_A   = 32'h0000_4000;
  localparam logic [31:0] STAT_A = 32'h0000_4004;

  logic clk;
  logic reset;
  logic uart_tx;
  logic tx_busy;
  logic overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b1;

  logic [7:0] sb[$];
  int         starts[$];

  mmio_uart_tx_if #(.DATA_WIDTH(32)) bus ();

  mmio_uart_tx #(
    .DATA_WIDTH   (32),
    .TX_ADDR      (TX_A),
    .STATUS_ADDR  (STAT_A),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.mem_write  = 1'b1;
    bus.data_addr  = addr;
    bus.write_data = data;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.mem_write = 1'b0;
    bus.data_addr = STAT_A;
    do begin
      @(negedge clk);
      n++;
    end while (!(!tx_busy && bus.rd_data[1]) && n < 2000);
    check("idle_timeout", 32'(n < 2000), 32'd1);
  endtask

  // Line monitor: samples each bit at its middle and scores the byte.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !uart_tx) begin
        starts.push_back(cyc);
        repeat (2) @(negedge clk);
        check("start_bit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        check("stop_bit", 32'(uart_tx), 32'd1);
        if (sb.size() == 0) check("sb_empty", {24'b0, b}, 32'hFFFF_FFFF);
        else                check("byte", {24'b0, b}, {24'b0, sb.pop_front()});
      end
      prev = uart_tx;
    end
  end

  initial begin
    int n;
    bus.mem_write  = 1'b0;
    bus.data_addr  = '0;
    bus.write_data = '0;

    // 1: reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    bus.data_addr = STAT_A;
    #1;
    check("rst_status", bus.rd_data, 32'h2);
    bus.data_addr = TX_A;
    #1;
    check("rd_other_addr", bus.rd_data, 32'h0);

    // 2: single frame 0x55, latency and busy length
    sb.push_back(8'h55);
    store(TX_A, 32'hFFFF_FF55);
    check("lat_e0", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    check("lat_e1", 32'(uart_tx), 32'd0);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (!tx_busy) break;
      n++;
    end
    check("busy_len", 32'(n), 32'd40);
    wait_idle();

    // 3: writes that must be ignored
    store(32'h0000_4008, 32'hAA);
    @(negedge clk);
    bus.mem_write  = 1'b0;
    bus.data_addr  = TX_A;
    bus.write_data = 32'h77;
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (!uart_tx) n++;
    end
    check("ignored_line", 32'(n), 32'd0);
    bus.data_addr = STAT_A;
    #1;
    check("ignored_status", bus.rd_data, 32'h2);

    // 4: overflow on six back-to-back stores
    starts.delete();
    for (int i = 0; i < 5; i++) sb.push_back(8'(8'h41 + i));
    for (int i = 0; i < 6; i++) store(TX_A, 32'(32'h41 + i));
    check("ovf_set", 32'(overflow), 32'd1);
    bus.data_addr = STAT_A;
    #1;
    check("ovf_status", bus.rd_data, 32'hD);
    store(STAT_A, 32'h8);
    check("ovf_clear", 32'(overflow), 32'd0);
    check("ovf_clr_status", bus.rd_data, 32'h5);
    wait_idle();
    check("ovf_frames", 32'(starts.size()), 32'd5);
    for (int i = 0; i + 1 < starts.size(); i++)
      check("frame_gap", 32'(starts[i+1] - starts[i]), 32'd41);

    // 5: reset mid-frame
    mon_en = 1'b0;
    store(TX_A, 32'h0F);
    store(TX_A, 32'h77);
    repeat (16) @(posedge clk);
    #1;
    check("pre_rst_bit3", 32'(uart_tx), 32'd1);
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_tx", 32'(uart_tx), 32'd1);
    check("async_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.data_addr = STAT_A;
    #1;
    check("post_rst_status", bus.rd_data, 32'h2);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (!uart_tx) n++;
    end
    check("queue_lost", 32'(n), 32'd0);
    mon_en = 1'b1;
    sb.push_back(8'h3C);
    store(TX_A, 32'h3C);
    wait_idle();

    // 6: push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 6; i++) sb.push_back(8'(8'h11 + i));
    for (int i = 0; i < 5; i++) store(TX_A, 32'(32'h11 + i));
    bus.data_addr = STAT_A;
    #1;
    check("full_status", bus.rd_data, 32'h5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 200);
    check("pop_wait_timeout", 32'(n < 200), 32'd1);
    bus.mem_write  = 1'b1;
    bus.data_addr  = TX_A;
    bus.write_data = 32'h16;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    bus.data_addr = STAT_A;
    #1;
    check("pushpop_ovf", 32'(overflow), 32'd0);
    check("pushpop_status", bus.rd_data, 32'h5);
    wait_idle();
    repeat (10) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
